// File: rtl/eth_rx_framer.sv
// eth_rx_framer: packs RMII dibits into bytes, strips the FCS and reports per-frame CRC/length/alignment status.
module eth_rx_framer #(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int LEN_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           in,
    input  logic                 inclk,
    input  logic                 done,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 frame_end,
    output logic                 frame_good,
    output logic                 crc_err,
    output logic                 len_err,
    output logic                 align_err,
    output logic [LEN_WIDTH-1:0] frame_len
);
    localparam logic [31:0]          POLY    = 32'hedb88320;
    localparam logic [31:0]          RESIDUE = 32'hdebb20e3;
    localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] FCS_L   = LEN_WIDTH'(4);
    localparam logic [LEN_WIDTH-1:0] FIRST_L = LEN_WIDTH'(5);

    logic [1:0]           idx;
    logic [5:0]           sh;
    logic [31:0]          crc, crc_a, crc_n;
    logic [LEN_WIDTH-1:0] cnt, cnt_n;
    logic [3:0][7:0]      dl;
    logic                 active, byte_done, emit, c_err, l_err, a_err;

    always_comb begin
        crc_a     = (crc >> 1) ^ ((crc[0] ^ in[0]) ? POLY : 32'h0);
        crc_n     = (crc_a >> 1) ^ ((crc_a[0] ^ in[1]) ? POLY : 32'h0);
        cnt_n     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        byte_done = inclk && !done && idx == 2'd3;
        emit      = byte_done && cnt_n >= FIRST_L && cnt_n <= MAX_L;
        c_err     = crc != RESIDUE;
        l_err     = cnt < MIN_L || cnt > MAX_L;
        a_err     = idx != 2'd0;
    end

    // done has priority over inclk, so a coincident dibit is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_end  <= 1'b0;
            frame_good <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            align_err  <= 1'b0;
            frame_len  <= '0;
            idx        <= '0;
            sh         <= '0;
            crc        <= '1;
            cnt        <= '0;
            dl         <= '0;
            active     <= 1'b0;
        end else begin
            out_valid <= emit;
            frame_end <= done && active;
            if (emit) out_data <= dl[3];
            if (done) begin
                if (active) begin
                    crc_err    <= c_err;
                    len_err    <= l_err;
                    align_err  <= a_err;
                    frame_good <= !(c_err || l_err || a_err);
                    frame_len  <= (cnt >= FCS_L) ? cnt - FCS_L : '0;
                end
                idx    <= '0;
                crc    <= '1;
                cnt    <= '0;
                dl     <= '0;
                active <= 1'b0;
            end else if (inclk) begin
                idx    <= idx + 2'd1;
                sh     <= {in, sh[5:2]};
                crc    <= crc_n;
                active <= 1'b1;
                if (byte_done) begin
                    cnt <= cnt_n;
                    dl  <= {dl[2:0], in, sh};
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer: random and directed frames checked against a frame-level reference model.
module tb_eth_rx_framer;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int LW      = 11;
    localparam logic [31:0] POLY = 32'hedb88320;

    logic          clk = 1'b0, reset = 1'b0, inclk = 1'b0, done = 1'b0;
    logic [1:0]    in = 2'b00;
    logic [7:0]    out_data;
    logic          out_valid, frame_end, frame_good, crc_err, len_err, align_err;
    logic [LW-1:0] frame_len;

    int         checks = 0, errors = 0, fe_cnt = 0;
    logic [7:0] frm[$], got[$];
    logic [1:0] xtra[$];

    eth_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .in(in), .inclk(inclk), .done(done),
        .out_data(out_data), .out_valid(out_valid), .frame_end(frame_end),
        .frame_good(frame_good), .crc_err(crc_err), .len_err(len_err),
        .align_err(align_err), .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) got.push_back(out_data);
        if (frame_end) fe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] c, input logic b);
        return (c[0] ^ b) ? (c >> 1) ^ POLY : c >> 1;
    endfunction

    function automatic void add_fcs();
        logic [31:0] c = '1;
        foreach (frm[i]) for (int b = 0; b < 8; b++) c = step(c, frm[i][b]);
        c = ~c;
        for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
    endfunction

    function automatic void rand_frame(input int n, input bit fcs);
        frm.delete();
        xtra.delete();
        repeat (n) frm.push_back(8'($urandom));
        if (fcs) add_fcs();
    endfunction

    task automatic send_dibit(input logic [1:0] d);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in = d;
        inclk = 1'b1;
        @(negedge clk);
        inclk = 1'b0;
    endtask

    task automatic run_frame(input bit coinc);
        int total, n_out, nbad;
        logic [31:0] c;
        logic exp_crc, exp_len, exp_align;
        got.delete();
        total = frm.size();
        foreach (frm[i]) for (int k = 0; k < 4; k++) begin
            send_dibit(frm[i][2*k +: 2]);
            if (i == 4 && k == 3) begin
                chk("first_valid_latency", out_valid, 1);
                chk("first_byte", out_data, frm[0]);
            end
        end
        foreach (xtra[i]) send_dibit(xtra[i]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        done = 1'b1;
        if (coinc) begin
            inclk = 1'b1;
            in = 2'($urandom);
        end
        @(negedge clk);
        done = 1'b0;
        inclk = 1'b0;
        c = '1;
        foreach (frm[i]) for (int b = 0; b < 8; b++) c = step(c, frm[i][b]);
        foreach (xtra[i]) for (int b = 0; b < 2; b++) c = step(c, xtra[i][b]);
        exp_crc   = c != 32'hdebb20e3;
        exp_len   = total < MIN_LEN || total > MAX_LEN;
        exp_align = xtra.size() != 0;
        n_out = (total > MAX_LEN ? MAX_LEN : total) - 4;
        if (n_out < 0) n_out = 0;
        chk("frame_end", frame_end, 1);
        chk("crc_err", crc_err, exp_crc);
        chk("len_err", len_err, exp_len);
        chk("align_err", align_err, exp_align);
        chk("frame_good", frame_good, !(exp_crc || exp_len || exp_align));
        chk("frame_len", frame_len, (total >= 4) ? total - 4 : 0);
        chk("out_count", got.size(), n_out);
        nbad = 0;
        for (int i = 0; i < got.size() && i < n_out; i++) if (got[i] !== frm[i]) nbad++;
        chk("out_data_mismatches", nbad, 0);
        @(negedge clk);
        chk("frame_end_pulse", frame_end, 0);
        chk("status_hold", frame_len, (total >= 4) ? total - 4 : 0);
    endtask

    initial begin
        int fe0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_status", {frame_good, crc_err, len_err, align_err}, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b1;
        @(negedge clk);

        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        chk("spurious_done", fe_cnt, 0);

        frm.delete();
        xtra.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        add_fcs();
        run_frame(1'b0);
        chk("t1_good", frame_good, 1);
        chk("t1_len", frame_len, 60);

        frm[60] = frm[60] ^ 8'h01;
        run_frame(1'b0);
        chk("t2_crc_err", crc_err, 1);
        chk("t2_len_err", len_err, 0);

        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        run_frame(1'b0);
        chk("t3_crc_err", crc_err, 0);
        chk("t3_len_err", len_err, 1);
        chk("t3_len", frame_len, 9);

        rand_frame(60, 1'b1);
        xtra.push_back(2'b01);
        run_frame(1'b0);
        chk("t4_align", align_err, 1);
        chk("t4_len", frame_len, 60);

        rand_frame(1515, 1'b1);
        run_frame(1'b0);
        chk("t5_count", got.size(), 1514);
        chk("t5_len_err", len_err, 1);

        for (int f = 0; f < 2; f++) begin
            rand_frame($urandom_range(60, 200), 1'b1);
            run_frame(1'b0);
            chk("b2b_good", frame_good, 1);
        end

        frm.delete();
        xtra.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i + 1));
        add_fcs();
        fe0 = fe_cnt;
        for (int i = 0; i < 30; i++) for (int k = 0; k < 4; k++) send_dibit(frm[i][2*k +: 2]);
        #3 reset = 1'b0;
        #1;
        chk("midrst_out_data", out_data, 0);
        chk("midrst_status", {out_valid, frame_end, frame_good, crc_err, len_err, align_err}, 0);
        chk("midrst_frame_len", frame_len, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_frame_end", fe_cnt, fe0);
        run_frame(1'b0);
        chk("midrst_next_good", frame_good, 1);

        rand_frame(3, 1'b0);
        run_frame(1'b0);
        chk("short_len", frame_len, 0);

        rand_frame(60, 1'b1);
        run_frame(1'b1);
        chk("coinc_good", frame_good, 1);

        for (int f = 0; f < 20; f++) begin
            rand_frame($urandom_range(1, 120), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) xtra.push_back(2'($urandom));
            run_frame($urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_rx_framer.md
Name: eth_rx_framer

Overview:
- Sits directly downstream of the RMII receive driver and consumes its dibit stream (in, inclk, done).
- Packs dibits LSB-first into bytes and strips the trailing 4-byte FCS through a 4-byte delay line.
- Checks the CRC-32 residue, frame length and dibit alignment, then reports per-frame status to the packet buffer / decrypt stage.
- No backpressure: the PHY cannot be stalled.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518, maximum legal frame length in bytes, FCS included.
- LEN_WIDTH, 11, width of the frame_len output.

Ports:
- clk  input  1  50 MHz RMII reference clock.
- reset  input  1  asynchronous, active-low reset (low = reset).
- in  input  2  received dibit, valid when inclk=1.
- inclk  input  1  one-cycle strobe per dibit.
- done  input  1  one-cycle pulse at end of frame; never coincident with inclk.
- out_data  output  8  payload byte, FCS excluded.
- out_valid  output  1  one-cycle strobe per payload byte.
- frame_end  output  1  one-cycle pulse; status outputs are valid in this cycle.
- frame_good  output  1  high when crc_err, len_err and align_err are all 0.
- crc_err  output  1  CRC residue mismatch.
- len_err  output  1  total length < MIN_LEN or > MAX_LEN.
- align_err  output  1  dibit count not a multiple of 4.
- frame_len  output  LEN_WIDTH  payload bytes = total bytes - 4, floored at 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - CRC register = 32'hffffffff; dibit index, byte count and delay line cleared.
  - Takes effect immediately, including mid-frame; the partial frame is discarded with no frame_end.
- Byte packing:
  - 2-bit dibit index counts inclk strobes.
  - Dibit k of a byte goes to bits [2k+1:2k].
  - The byte completes on the strobe with index=3.
- CRC:
  - Reflected polynomial 32'hedb88320, 2 bits per inclk, LSB-first.
  - Bit 0 of the dibit is shifted first.
  - Applied to every dibit, FCS included.
  - At end of frame, a good frame leaves raw register = 32'hdebb20e3. Any other value sets crc_err.
- Delay line:
  - 4-byte shift register.
  - On each byte completion, when the byte count after increment is ≥5, the oldest byte is presented on out_data and out_valid pulses in the next cycle.
  - out_data holds its value until the next emission.
- Length:
  - Byte counter saturates at 2^LEN_WIDTH-1.
  - Once the total exceeds MAX_LEN, no further out_valid pulses; len_err is reported at frame end.
- End of frame (done sampled high):
  - Next cycle: frame_end=1 with all status outputs and frame_len registered.
  - Status outputs hold until the next frame_end.
  - Delay line contents (the FCS) are discarded.
  - CRC, byte count and dibit index reinitialise in the same cycle.
- align_err: dibit index ≠ 0 at done. A trailing partial byte is not counted and not emitted.
- Spurious done (no dibits since the last frame end or reset): ignored, no frame_end.
- Frames with total < 5 bytes: no out_valid, frame_len = total-4 floored at 0, len_err=1.
- inclk and done coincident (protocol violation): done wins and the dibit is dropped.
- Latency:
  - out_valid: 1 cycle after the completing inclk of byte n+4.
  - frame_end: 1 cycle after done.

Test Plan:
- 60 payload bytes 0x00..0x3B + correct FCS (64 total) -> 60 out_valid pulses with data 0x00..0x3B in order; frame_end with frame_good=1, all errors 0, frame_len=60.
- Same frame with bit 0 of the first FCS byte flipped -> same 60 bytes; crc_err=1, frame_good=0, len_err=0.
- ASCII "123456789" + FCS bytes 26 39 F4 CB (13 total) -> 9 bytes 0x31..0x39 emitted; crc_err=0, len_err=1, frame_len=9.
- Valid 64-byte frame plus one extra dibit before done -> align_err=1, frame_good=0, frame_len=60.
- 1519-byte frame -> exactly 1514 out_valid pulses; len_err=1.
- Back-to-back: first frame ends as good; the next frame is valid with crc_err=0, confirming CRC reinit.
- Reset mid-frame:
  - Reset at byte 30 of 64 -> outputs 0 at once; the following done produces no frame_end.
  - The next full valid frame then reports frame_good=1.
